// File: rtl/cmask_pkg.sv
// ============================================================================
//  Module      : cmask_pkg
//  Description : Shared types and op encodings for the crossbar-mask range
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmask_pkg;

    localparam logic [1:0] c_OP_SET   = 2'd0;
    localparam logic [1:0] c_OP_SHIFT = 2'd1;
    localparam logic [1:0] c_OP_ALL   = 2'd2;
    localparam logic [1:0] c_OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        OP_SET   = c_OP_SET,
        OP_SHIFT = c_OP_SHIFT,
        OP_ALL   = c_OP_ALL,
        OP_RSVD  = c_OP_RSVD
    } cmask_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_VALID  = 2'd2
    } cmask_state_t;

endpackage

`default_nettype wire

// File: rtl/cmask_range_check.sv
// ============================================================================
//  Module      : cmask_range_check
//  Description : Combinational legality check and next-range computation for
//                SET / SHIFT / ALL mask commands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmask_range_check
    import cmask_pkg::*;
#(
    parameter int NUM_CROSSBAR = 1024,
    parameter int SRC_SIZE     = 10
) (
    input  logic [1:0]          op,
    input  logic [SRC_SIZE-1:0] opd_start,
    input  logic [SRC_SIZE-1:0] opd_end,
    input  logic [SRC_SIZE-1:0] cur_start,
    input  logic [SRC_SIZE-1:0] cur_end,
    input  cmask_state_t        state,
    output logic                legal,
    output logic [SRC_SIZE-1:0] nxt_start,
    output logic [SRC_SIZE-1:0] nxt_end
);

    localparam logic [SRC_SIZE:0] c_MAX_IDX = (SRC_SIZE+1)'(NUM_CROSSBAR - 1);

    logic [SRC_SIZE:0]   w_sum_end;
    logic [SRC_SIZE-1:0] w_sum_start;

    // Start never exceeds end, so the start sum fits whenever the end sum does.
    assign w_sum_end   = {1'b0, cur_end} + {1'b0, opd_start};
    assign w_sum_start = cur_start + opd_start;

    always_comb begin
        legal     = 1'b0;
        nxt_start = cur_start;
        nxt_end   = cur_end;
        case (op)
            c_OP_SET: begin
                legal     = (opd_start <= opd_end) && ({1'b0, opd_end} <= c_MAX_IDX);
                nxt_start = opd_start;
                nxt_end   = opd_end;
            end
            c_OP_ALL: begin
                legal     = 1'b1;
                nxt_start = '0;
                nxt_end   = c_MAX_IDX[SRC_SIZE-1:0];
            end
            c_OP_SHIFT: begin
                legal     = (state == ST_VALID) && (w_sum_end <= c_MAX_IDX);
                nxt_start = w_sum_start;
                nxt_end   = w_sum_end[SRC_SIZE-1:0];
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cmask_range_ctrl.sv
// ============================================================================
//  Module      : cmask_range_ctrl
//  Description : Command-driven owner of the crossbar-mask range registers;
//                tracks generator settling and flags a usable mask.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmask_range_ctrl
    import cmask_pkg::*;
#(
    parameter int NUM_CROSSBAR  = 1024,
    parameter int SRC_SIZE      = 10,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [SRC_SIZE-1:0] cmd_start,
    input  logic [SRC_SIZE-1:0] cmd_end,
    output logic [SRC_SIZE-1:0] C_start,
    output logic [SRC_SIZE-1:0] C_end,
    output logic                mask_valid,
    output logic                err
);

    localparam int c_CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    cmask_state_t        r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [SRC_SIZE-1:0] r_c_start;
    logic [SRC_SIZE-1:0] r_c_end;
    logic                r_mask_valid;
    logic                r_err;

    logic                w_accept;
    logic                w_legal;
    logic [SRC_SIZE-1:0] w_nxt_start;
    logic [SRC_SIZE-1:0] w_nxt_end;

    cmask_range_check #(
        .NUM_CROSSBAR (NUM_CROSSBAR),
        .SRC_SIZE     (SRC_SIZE)
    ) u_check (
        .op        (cmd_op),
        .opd_start (cmd_start),
        .opd_end   (cmd_end),
        .cur_start (r_c_start),
        .cur_end   (r_c_end),
        .state     (r_state),
        .legal     (w_legal),
        .nxt_start (w_nxt_start),
        .nxt_end   (w_nxt_end)
    );

    // Ready follows registered state only; reset gates it so nothing is taken mid-reset.
    assign cmd_ready  = (r_state != ST_SETTLE) && !reset;
    assign w_accept   = cmd_valid && cmd_ready;
    assign C_start    = r_c_start;
    assign C_end      = r_c_end;
    assign mask_valid = r_mask_valid;
    assign err        = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_c_start    <= '0;
            r_c_end      <= '0;
            r_mask_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_SETTLE: begin
                    if (r_cnt <= c_CNT_W'(1)) begin
                        r_state      <= ST_VALID;
                        r_mask_valid <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_state      <= ST_SETTLE;
                            r_cnt        <= c_CNT_W'(SETTLE_CYCLES);
                            r_mask_valid <= 1'b0;
                            r_c_start    <= w_nxt_start;
                            r_c_end      <= w_nxt_end;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmask_range_ctrl.sv
// ============================================================================
//  Module      : tb_cmask_range_ctrl
//  Description : Self-checking bench for cmask_range_ctrl (settle 1 and 3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmask_range_ctrl;
    import cmask_pkg::*;

    localparam int N  = 1024;
    localparam int W  = 10;
    localparam int SA = 1;
    localparam int SB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst, a_v, a_rdy, a_mv, a_err;
    logic [1:0]   a_op;
    logic [W-1:0] a_si, a_ei, a_cs, a_ce;
    logic         b_rst, b_v, b_rdy, b_mv, b_err;
    logic [1:0]   b_op;
    logic [W-1:0] b_si, b_ei, b_cs, b_ce;

    int checks = 0;
    int errors = 0;

    // Reference model for unit A: range, whether a mask was ever defined,
    // cycles left until the mask is usable, and the pending error pulse.
    int m_s, m_e, m_wait;
    bit m_def, m_err;

    cmask_range_ctrl #(.NUM_CROSSBAR(N), .SRC_SIZE(W), .SETTLE_CYCLES(SA)) dut_a (
        .clock(clk), .reset(a_rst), .cmd_valid(a_v), .cmd_ready(a_rdy), .cmd_op(a_op),
        .cmd_start(a_si), .cmd_end(a_ei), .C_start(a_cs), .C_end(a_ce),
        .mask_valid(a_mv), .err(a_err));

    cmask_range_ctrl #(.NUM_CROSSBAR(N), .SRC_SIZE(W), .SETTLE_CYCLES(SB)) dut_b (
        .clock(clk), .reset(b_rst), .cmd_valid(b_v), .cmd_ready(b_rdy), .cmd_op(b_op),
        .cmd_start(b_si), .cmd_end(b_ei), .C_start(b_cs), .C_end(b_ce),
        .mask_valid(b_mv), .err(b_err));

    task automatic drive_a(input logic r, input logic v, input logic [1:0] op,
                           input int s, input int e);
        bit rdy, legal;
        int ns, ne;
        a_rst = r; a_v = v; a_op = op; a_si = W'(s); a_ei = W'(e);
        @(posedge clk);
        if (r) begin
            m_s = 0; m_e = 0; m_def = 0; m_wait = 0; m_err = 0;
        end else begin
            rdy   = (m_wait == 0);
            m_err = 0;
            if (m_wait > 0) m_wait--;
            if (v && rdy) begin
                legal = 0; ns = m_s; ne = m_e;
                case (op)
                    c_OP_SET:   begin ns = s; ne = e; legal = (s <= e) && (e <= N - 1); end
                    c_OP_ALL:   begin ns = 0; ne = N - 1; legal = 1; end
                    c_OP_SHIFT: begin ns = m_s + s; ne = m_e + s; legal = m_def && (ne <= N - 1); end
                    default:    legal = 0;
                endcase
                if (legal) begin
                    m_s = ns; m_e = ne; m_def = 1; m_wait = SA;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_b(input logic r, input logic v, input logic [1:0] op,
                           input int s, input int e);
        b_rst = r; b_v = v; b_op = op; b_si = W'(s); b_ei = W'(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        drive_a(1, 1, c_OP_SET, 5, 9);
        drive_a(1, 1, c_OP_SET, 5, 9);
        checks++;
        if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", a_rdy); end
        checks++;
        if (a_cs !== 0 || a_ce !== 0 || a_mv !== 1'b0 || a_err !== 1'b0) begin
            errors++; $display("FAIL reset_state got %0d..%0d mv %b err %b want 0..0 mv 0 err 0", a_cs, a_ce, a_mv, a_err);
        end
    endtask

    task automatic test_set;
        drive_a(0, 1, c_OP_SET, 5, 9);
        checks++;
        if (a_cs !== 5 || a_ce !== 9 || a_mv !== 1'b0) begin
            errors++; $display("FAIL set_accept got %0d..%0d mv %b want 5..9 mv 0", a_cs, a_ce, a_mv);
        end
        drive_a(0, 0, c_OP_SET, 0, 0);
        checks++;
        if (a_mv !== 1'b1 || a_rdy !== 1'b1) begin
            errors++; $display("FAIL set_settle got mv %b rdy %b want 1 1", a_mv, a_rdy);
        end
    endtask

    task automatic test_bad_set;
        drive_a(0, 1, c_OP_SET, 20, 10);
        checks++;
        if (a_err !== 1'b1 || a_cs !== 5 || a_ce !== 9 || a_mv !== 1'b1 || a_rdy !== 1'b1) begin
            errors++; $display("FAIL bad_set got err %b %0d..%0d mv %b rdy %b want 1 5..9 1 1", a_err, a_cs, a_ce, a_mv, a_rdy);
        end
        drive_a(0, 0, c_OP_SET, 0, 0);
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL bad_set_pulse got err %b want 0", a_err); end
    endtask

    task automatic test_shift;
        drive_a(0, 1, c_OP_SHIFT, 1000, 0);
        checks++;
        if (a_cs !== 1005 || a_ce !== 1009 || a_err !== 1'b0 || a_mv !== 1'b0) begin
            errors++; $display("FAIL shift_ok got %0d..%0d err %b mv %b want 1005..1009 0 0", a_cs, a_ce, a_err, a_mv);
        end
        drive_a(0, 0, c_OP_SET, 0, 0);
        drive_a(0, 1, c_OP_SHIFT, 20, 0);
        checks++;
        if (a_err !== 1'b1 || a_cs !== 1005 || a_ce !== 1009 || a_mv !== 1'b1) begin
            errors++; $display("FAIL shift_over got err %b %0d..%0d mv %b want 1 1005..1009 1", a_err, a_cs, a_ce, a_mv);
        end
    endtask

    task automatic test_shift_idle;
        drive_a(1, 0, c_OP_SET, 0, 0);
        drive_a(0, 1, c_OP_SHIFT, 3, 0);
        checks++;
        if (a_err !== 1'b1 || a_cs !== 0 || a_ce !== 0 || a_mv !== 1'b0 || a_rdy !== 1'b1) begin
            errors++; $display("FAIL shift_idle got err %b %0d..%0d mv %b rdy %b want 1 0..0 0 1", a_err, a_cs, a_ce, a_mv, a_rdy);
        end
    endtask

    task automatic test_back_to_back;
        int busy;
        drive_b(1, 0, c_OP_SET, 0, 0);
        drive_b(0, 1, c_OP_ALL, 0, 0);
        checks++;
        if (b_cs !== 0 || b_ce !== N - 1 || b_mv !== 1'b0) begin
            errors++; $display("FAIL b2b_all got %0d..%0d mv %b want 0..1023 0", b_cs, b_ce, b_mv);
        end
        busy = 0;
        for (int i = 0; i < 10 && b_rdy !== 1'b1; i++) begin
            busy++;
            drive_b(0, 1, c_OP_SET, 0, 0);
        end
        checks++;
        if (busy !== SB || b_mv !== 1'b1 || b_ce !== N - 1) begin
            errors++; $display("FAIL b2b_backpressure got busy %0d mv %b end %0d want %0d 1 1023", busy, b_mv, b_ce, SB);
        end
        drive_b(0, 1, c_OP_SET, 0, 0);
        checks++;
        if (b_cs !== 0 || b_ce !== 0 || b_mv !== 1'b0 || b_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b_set got %0d..%0d mv %b rdy %b want 0..0 0 0", b_cs, b_ce, b_mv, b_rdy);
        end
    endtask

    task automatic test_reset_mid_settle;
        drive_b(0, 0, c_OP_SET, 0, 0);
        drive_b(0, 0, c_OP_SET, 0, 0);
        drive_b(0, 0, c_OP_SET, 0, 0);
        drive_b(0, 1, c_OP_SET, 7, 12);
        drive_b(0, 0, c_OP_SET, 0, 0);
        checks++;
        if (b_cs !== 7 || b_ce !== 12 || b_rdy !== 1'b0) begin
            errors++; $display("FAIL mid_settle_pre got %0d..%0d rdy %b want 7..12 0", b_cs, b_ce, b_rdy);
        end
        drive_b(1, 0, c_OP_SET, 0, 0);
        checks++;
        if (b_cs !== 0 || b_ce !== 0 || b_mv !== 1'b0 || b_err !== 1'b0) begin
            errors++; $display("FAIL mid_settle_reset got %0d..%0d mv %b err %b want 0..0 0 0", b_cs, b_ce, b_mv, b_err);
        end
        drive_b(0, 0, c_OP_SET, 0, 0);
        drive_b(0, 0, c_OP_SET, 0, 0);
        drive_b(0, 0, c_OP_SET, 0, 0);
        drive_b(0, 0, c_OP_SET, 0, 0);
        checks++;
        if (b_mv !== 1'b0 || b_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_settle_abandon got mv %b rdy %b want 0 1", b_mv, b_rdy);
        end
    endtask

    task automatic test_random;
        logic r, v;
        logic [1:0] op;
        int s, e;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            s  = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, N - 1);
            e  = $urandom_range(0, 1) ? s + $urandom_range(0, 30) : $urandom_range(0, N - 1);
            if (e > N - 1) e = N - 1;
            drive_a(r, v, op, s, e);
            checks++;
            if (a_cs !== W'(m_s) || a_ce !== W'(m_e)) begin
                errors++; $display("FAIL rand_range cyc %0d got %0d..%0d want %0d..%0d", i, a_cs, a_ce, m_s, m_e);
            end
            checks++;
            if (a_mv !== (m_def && m_wait == 0)) begin
                errors++; $display("FAIL rand_mask_valid cyc %0d got %b want %b", i, a_mv, (m_def && m_wait == 0));
            end
            checks++;
            if (a_rdy !== (m_wait == 0 && !r)) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b want %b", i, a_rdy, (m_wait == 0 && !r));
            end
            checks++;
            if (a_err !== m_err) begin
                errors++; $display("FAIL rand_err cyc %0d got %b want %b", i, a_err, m_err);
            end
        end
    endtask

    initial begin
        a_rst = 1; a_v = 0; a_op = '0; a_si = '0; a_ei = '0;
        b_rst = 1; b_v = 0; b_op = '0; b_si = '0; b_ei = '0;
        m_s = 0; m_e = 0; m_wait = 0; m_def = 0; m_err = 0;
        test_reset;
        test_set;
        test_bad_set;
        test_shift;
        test_shift_idle;
        test_back_to_back;
        test_reset_mid_settle;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
